spi_mem_responder: RTL and testbench



---
 rtl/spi_mem_responder_pkg.sv | 12 +
 rtl/spi_mem_responder_if.sv | 28 ++
 rtl/spi_pin_sync.sv | 37 +++
 rtl/spi_mem_responder.sv | 157 +++++++++++++++
 tb/tb_spi_mem_responder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_responder_pkg.sv
// Shared SPI memory command constants, common to this responder and the SPI memory controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_mem_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    // Default width of the byte address presented on the memory port.
    localparam int SPI_ADDR_W_DEF = 16;

endpackage

// File: rtl/spi_mem_responder_if.sv
// Byte-wide synchronous memory port between the SPI responder and its backing store.
// Latency: mem_rdata_in is valid the cycle after mem_re_out.
// Backpressure: none; the memory must accept every strobe.
// Ports: mem_addr_out, mem_re_out, mem_we_out, mem_wdata_out (responder -> memory),
//        mem_rdata_in (memory -> responder).
interface spi_mem_responder_if
    import spi_mem_responder_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W_DEF
);
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_re_out;
    logic [7:0]        mem_rdata_in;
    logic              mem_we_out;
    logic [7:0]        mem_wdata_out;

    // Responder side drives the address and strobes.
    modport master (
        output mem_addr_out, mem_re_out, mem_we_out, mem_wdata_out,
        input  mem_rdata_in
    );

    // Memory side returns read data.
    modport slave (
        input  mem_addr_out, mem_re_out, mem_we_out, mem_wdata_out,
        output mem_rdata_in
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous pin, plus rise/fall detection on the synced level.
// Latency: sync_out 2 cycles after the pin; rise_out/fall_out are combinational from sync, so an
//          edge acts on the 3rd clk_in edge. Backpressure: none.
// Ports: clk_in, reset_in, pin_in -> sync_out, rise_out, fall_out.
module spi_pin_sync
    import spi_mem_responder_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic pin_in,
    output logic sync_out,
    output logic rise_out,
    output logic fall_out
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= pin_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise_out = sync_q & ~prev_q;
    assign fall_out = ~sync_q & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target serving READ (0x03) / WRITE (0x02) + 24-bit address onto a byte-wide memory port.
// Latency: 3 clk_in cycles pin-to-action; read prefetch lands 2 cycles after the detected rise,
//          write strobe 1 cycle after the detected 8th rise. Backpressure: none (memory never stalls).
// Ports: clk_in, reset_in, sclk_in/mosi_in/cs_n_in (async pins), miso_out, busy_out, mem_bus (master).
module spi_mem_responder
    import spi_mem_responder_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W_DEF
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                sclk_in,
    input  logic                mosi_in,
    input  logic                cs_n_in,
    output logic                miso_out,
    output logic                busy_out,
    spi_mem_responder_if.master mem_bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_IGNORE
    } state_t;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_fall, cs_rise_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused, sclk_s_unused;

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk_in(clk_in), .reset_in(reset_in), .pin_in(sclk_in),
        .sync_out(sclk_s), .rise_out(sclk_rise), .fall_out(sclk_fall)
    );
    spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk_in(clk_in), .reset_in(reset_in), .pin_in(cs_n_in),
        .sync_out(cs_n_s), .rise_out(cs_rise_unused), .fall_out(cs_fall)
    );
    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk_in(clk_in), .reset_in(reset_in), .pin_in(mosi_in),
        .sync_out(mosi_s), .rise_out(mosi_rise_unused), .fall_out(mosi_fall_unused)
    );
    assign sclk_s_unused = sclk_s;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [7:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic [ADDR_W-1:0] addr_q;
    logic              is_read;
    logic              re_q, pf_q, we_q, miso_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rx_next;
    logic              last_bit;

    // Byte as it will look once the bit sampled on this rise is shifted in.
    assign rx_next  = {rx_sr[6:0], mosi_s};
    assign last_bit = (bit_cnt == 3'd7);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_n_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (sclk_rise && last_bit) begin
                        if (rx_next == SPI_CMD_READ || rx_next == SPI_CMD_WRITE) state_d = ST_ADDR;
                        else                                                     state_d = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise && last_bit && byte_cnt == 2'd2)
                        state_d = is_read ? ST_READ : ST_WRITE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy_out = (state_q != ST_IDLE);
        miso_out = (state_q == ST_READ) ? miso_q : 1'b0;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            addr_q   <= '0;
            is_read  <= 1'b0;
            re_q     <= 1'b0;
            pf_q     <= 1'b0;
            we_q     <= 1'b0;
            miso_q   <= 1'b0;
            wdata_q  <= '0;
        end else begin
            re_q <= 1'b0;
            we_q <= 1'b0;
            pf_q <= re_q;
            // Address moves on only after the write strobe has been seen with the old value.
            if (we_q) addr_q <= addr_q + 1'b1;

            if (cs_n_s) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                pf_q     <= 1'b0;
                miso_q   <= 1'b0;
            end else if (sclk_rise && state_q != ST_IDLE) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + 1'b1;
                case (state_q)
                    ST_CMD: if (last_bit) is_read <= (rx_next == SPI_CMD_READ);
                    ST_ADDR: begin
                        // Shifting all 24 bits through keeps only the low ADDR_W.
                        addr_q <= {addr_q[ADDR_W-2:0], mosi_s};
                        if (last_bit) begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == 2'd2 && is_read) re_q <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        if (last_bit) begin
                            addr_q <= addr_q + 1'b1;
                            re_q   <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (last_bit) begin
                            we_q    <= 1'b1;
                            wdata_q <= rx_next;
                        end
                    end
                    default: ;
                endcase
            end else if (sclk_fall && state_q == ST_READ) begin
                // Each byte is loaded between its predecessor's 8th rise and the next fall,
                // so a plain shift-out on every fall presents the MSB first.
                miso_q <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
            end

            if (pf_q && !cs_n_s) tx_sr <= mem_bus.mem_rdata_in;
        end
    end

    assign mem_bus.mem_addr_out  = addr_q;
    assign mem_bus.mem_re_out    = re_q;
    assign mem_bus.mem_we_out    = we_q;
    assign mem_bus.mem_wdata_out = wdata_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: drives SPI mode-0 transfers and checks the memory strobes,
// returned miso bytes and busy timing against hand-computed values.
// Latency/backpressure: n/a (bench).
module tb_spi_mem_responder;
    import spi_mem_responder_pkg::*;

    localparam int H = 5;  // sclk half-period in clk_in cycles

    logic clk_in = 1'b0;
    logic reset_in, sclk, mosi, cs_n;
    logic miso, busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_in = ~clk_in;

    spi_mem_responder_if #(.ADDR_W(16)) mem_if ();

    spi_mem_responder #(.ADDR_W(16)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .sclk_in(sclk), .mosi_in(mosi),
        .cs_n_in(cs_n), .miso_out(miso), .busy_out(busy), .mem_bus(mem_if.master)
    );

    logic [7:0]  mem_arr [0:65535];
    logic [15:0] re_log[$];
    logic [15:0] we_addr_log[$];
    logic [7:0]  we_data_log[$];
    logic        both_seen = 1'b0;
    logic        miso_hi   = 1'b0;

    always @(posedge clk_in) begin
        if (mem_if.mem_re_out) begin
            mem_if.mem_rdata_in <= mem_arr[mem_if.mem_addr_out];
            re_log.push_back(mem_if.mem_addr_out);
        end
        if (mem_if.mem_we_out) begin
            mem_arr[mem_if.mem_addr_out] <= mem_if.mem_wdata_out;
            we_addr_log.push_back(mem_if.mem_addr_out);
            we_data_log.push_back(mem_if.mem_wdata_out);
        end
        if (mem_if.mem_re_out && mem_if.mem_we_out) both_seen = 1'b1;
    end

    always @(negedge clk_in) if (miso === 1'b1) miso_hi = 1'b1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            tick(H);
            rx[i] = miso;
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick(H);
    endtask

    task automatic cs_end();
        tick(H);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic clear_logs();
        re_log.delete();
        we_addr_log.delete();
        we_data_log.delete();
        miso_hi = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] d;
        spi_byte(cmd, d);
        spi_byte(a[23:16], d);
        spi_byte(a[15:8], d);
        spi_byte(a[7:0], d);
    endtask

    task automatic test_reset();
        reset_in = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tick(3);
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b want=0", miso); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (mem_if.mem_addr_out !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h want=0000", mem_if.mem_addr_out); end
        total++; if (mem_if.mem_re_out !== 1'b0) begin bad++; $display("FAIL rst_re got=%b want=0", mem_if.mem_re_out); end
        total++; if (mem_if.mem_we_out !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_if.mem_we_out); end
        total++; if (mem_if.mem_wdata_out !== 8'h0) begin bad++; $display("FAIL rst_wdata got=%h want=00", mem_if.mem_wdata_out); end
        reset_in = 1'b0;
        tick(3);
    endtask

    task automatic test_busy_latency();
        cs_n = 1'b0;
        tick(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_rise_early got=%b want=0", busy); end
        tick(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b want=1", busy); end
        cs_n = 1'b1;
        tick(2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_fall_early got=%b want=1", busy); end
        tick(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_fall got=%b want=0", busy); end
        tick(5);
    endtask

    task automatic test_read();
        logic [7:0] r0, r1;
        mem_arr[16'h001E] = 8'hA5;
        mem_arr[16'h001F] = 8'h3C;
        clear_logs();
        cs_start();
        send_hdr(SPI_CMD_READ, 24'h00001E);
        spi_byte(8'h00, r0);
        spi_byte(8'h00, r1);
        cs_end();
        total++; if ({r0, r1} !== 16'hA53C) begin bad++; $display("FAIL read_miso got=%h want=a53c", {r0, r1}); end
        total++; if (re_log.size() != 3) begin bad++; $display("FAIL read_re_count got=%0d want=3", re_log.size()); end
        if (re_log.size() >= 2) begin
            total++; if (re_log[0] !== 16'h001E) begin bad++; $display("FAIL read_re0 got=%h want=001e", re_log[0]); end
            total++; if (re_log[1] !== 16'h001F) begin bad++; $display("FAIL read_re1 got=%h want=001f", re_log[1]); end
        end
        total++; if (we_addr_log.size() != 0) begin bad++; $display("FAIL read_no_we got=%0d want=0", we_addr_log.size()); end
    endtask

    task automatic test_write();
        logic [7:0] d;
        clear_logs();
        cs_start();
        send_hdr(SPI_CMD_WRITE, 24'h000040);
        spi_byte(8'h5A, d);
        spi_byte(8'h77, d);
        cs_end();
        total++; if (we_addr_log.size() != 2) begin bad++; $display("FAIL write_count got=%0d want=2", we_addr_log.size()); end
        if (we_addr_log.size() >= 2) begin
            total++; if ({we_addr_log[0], we_data_log[0]} !== 24'h00405A) begin bad++; $display("FAIL write0 got=%h want=00405a", {we_addr_log[0], we_data_log[0]}); end
            total++; if ({we_addr_log[1], we_data_log[1]} !== 24'h004177) begin bad++; $display("FAIL write1 got=%h want=004177", {we_addr_log[1], we_data_log[1]}); end
        end
        total++; if (re_log.size() != 0) begin bad++; $display("FAIL write_no_re got=%0d want=0", re_log.size()); end
        total++; if (mem_if.mem_addr_out !== 16'h0042) begin bad++; $display("FAIL write_addr_inc got=%h want=0042", mem_if.mem_addr_out); end
    endtask

    task automatic test_ignore();
        logic [7:0] d, acc;
        clear_logs();
        acc = 8'h00;
        cs_start();
        spi_byte(8'h9F, d);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'hFF, d);
            acc = acc | d;
        end
        tick(H);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy got=%b want=1", busy); end
        cs_n = 1'b1;
        tick(8);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%b want=0", busy); end
        total++; if (acc !== 8'h00) begin bad++; $display("FAIL ignore_miso_bytes got=%h want=00", acc); end
        total++; if (miso_hi !== 1'b0) begin bad++; $display("FAIL ignore_miso_level got=%b want=0", miso_hi); end
        total++; if (re_log.size() + we_addr_log.size() != 0) begin bad++; $display("FAIL ignore_strobes got=%0d want=0", re_log.size() + we_addr_log.size()); end
    endtask

    task automatic test_wrap();
        logic [7:0] r0, r1;
        logic [23:0] addrs [2];
        mem_arr[16'hFFFF] = 8'hC3;
        mem_arr[16'h0000] = 8'h81;
        addrs[0] = 24'h00FFFF;
        addrs[1] = 24'h12FFFF;
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            cs_start();
            send_hdr(SPI_CMD_READ, addrs[k]);
            spi_byte(8'h00, r0);
            spi_byte(8'h00, r1);
            cs_end();
            total++; if ({r0, r1} !== 16'hC381) begin bad++; $display("FAIL wrap%0d_miso got=%h want=c381", k, {r0, r1}); end
            total++; if (re_log.size() < 2) begin bad++; $display("FAIL wrap%0d_count got=%0d want>=2", k, re_log.size()); end
            if (re_log.size() >= 2) begin
                total++; if ({re_log[0], re_log[1]} !== 32'hFFFF_0000) begin bad++; $display("FAIL wrap%0d_addrs got=%h want=ffff0000", k, {re_log[0], re_log[1]}); end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] d, r0, r1;
        mem_arr[16'h0051] = 8'h66;
        clear_logs();
        cs_start();
        send_hdr(SPI_CMD_WRITE, 24'h000050);
        spi_byte(8'h11, d);
        spi_bits(8'hF0, 4, d);
        cs_end();
        total++; if (we_addr_log.size() != 1) begin bad++; $display("FAIL abort_count got=%0d want=1", we_addr_log.size()); end
        if (we_addr_log.size() >= 1) begin
            total++; if ({we_addr_log[0], we_data_log[0]} !== 24'h005011) begin bad++; $display("FAIL abort_first got=%h want=005011", {we_addr_log[0], we_data_log[0]}); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", busy); end
        clear_logs();
        cs_start();
        send_hdr(SPI_CMD_READ, 24'h000050);
        spi_byte(8'h00, r0);
        spi_byte(8'h00, r1);
        cs_end();
        total++; if ({r0, r1} !== 16'h1166) begin bad++; $display("FAIL abort_readback got=%h want=1166", {r0, r1}); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        clear_logs();
        cs_start();
        send_hdr(SPI_CMD_READ, 24'h00001E);
        spi_bits(8'h00, 4, d);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        #2 reset_in = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL async_miso got=%b want=0", miso); end
        total++; if (mem_if.mem_addr_out !== 16'h0) begin bad++; $display("FAIL async_addr got=%h want=0000", mem_if.mem_addr_out); end
        total++; if (mem_if.mem_wdata_out !== 8'h0) begin bad++; $display("FAIL async_wdata got=%h want=00", mem_if.mem_wdata_out); end
        total++; if ({mem_if.mem_re_out, mem_if.mem_we_out} !== 2'b00) begin bad++; $display("FAIL async_strobes got=%b want=00", {mem_if.mem_re_out, mem_if.mem_we_out}); end
        cs_n = 1'b1; sclk = 1'b0;
        tick(3);
        reset_in = 1'b0;
        tick(3);
        clear_logs();
        cs_start();
        send_hdr(SPI_CMD_WRITE, 24'h000060);
        spi_byte(8'hAB, d);
        cs_end();
        total++; if (we_addr_log.size() != 1) begin bad++; $display("FAIL post_rst_count got=%0d want=1", we_addr_log.size()); end
        if (we_addr_log.size() >= 1) begin
            total++; if ({we_addr_log[0], we_data_log[0]} !== 24'h0060AB) begin bad++; $display("FAIL post_rst_write got=%h want=0060ab", {we_addr_log[0], we_data_log[0]}); end
        end
    endtask

    task automatic test_exclusive_strobes();
        total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL re_we_overlap got=%b want=0", both_seen); end
    endtask

    initial begin
        mem_if.mem_rdata_in = 8'h00;
        test_reset();
        test_busy_latency();
        test_read();
        test_write();
        test_ignore();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        test_exclusive_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
